// File: rtl/soc_bus_arb.sv
// Two-master arbiter for the shared slave bus: one transaction in flight, IDLE -> ADDR -> DATA.
// Define SOC_BUS_ARB_FIXED_PRIO_EN for fixed m0-first priority; round-robin otherwise.
module soc_bus_arb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,

  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_we_i,
  input  logic [2:0]        m0_size_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_we_i,
  input  logic [2:0]        m1_size_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,

  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [2:0]        bus_size_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic              bus_rd_o,
  output logic              bus_we_o,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } state_e;

  state_e            state_q;
  logic              win_id_q;
  logic              win_we_q;
  logic [1:0]        gnt_q;
  logic [1:0]        rvalid_q;
  logic              bus_rd_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [2:0]        bus_size_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;
`ifndef SOC_BUS_ARB_FIXED_PRIO_EN
  logic              last_q;
`endif

  logic              any_req;
  logic              pick;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_size;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  // Winner selection; pick = 1 selects m1.
  always_comb begin
    any_req = m0_req_i | m1_req_i;
`ifdef SOC_BUS_ARB_FIXED_PRIO_EN
    pick = ~m0_req_i;
`else
    if (m0_req_i && m1_req_i) begin
      pick = ~last_q;
    end else begin
      pick = m1_req_i;
    end
`endif
    sel_addr  = pick ? m1_addr_i  : m0_addr_i;
    sel_size  = pick ? m1_size_i  : m0_size_i;
    sel_wdata = pick ? m1_wdata_i : m0_wdata_i;
    sel_we    = pick ? m1_we_i    : m0_we_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      win_id_q    <= 1'b0;
      win_we_q    <= 1'b0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      bus_rd_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_size_q  <= '0;
      bus_wdata_q <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
`ifndef SOC_BUS_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      // Grant, strobes and completion are single-cycle pulses.
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      bus_rd_q <= 1'b0;
      bus_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q     <= StAddr;
            win_id_q    <= pick;
            win_we_q    <= sel_we;
            bus_addr_q  <= sel_addr;
            bus_size_q  <= sel_size;
            bus_wdata_q <= sel_wdata;
            bus_rd_q    <= ~sel_we;
            bus_we_q    <= sel_we;
            gnt_q       <= pick ? 2'b10 : 2'b01;
`ifndef SOC_BUS_ARB_FIXED_PRIO_EN
            last_q      <= pick;
`endif
          end
        end
        StAddr: begin
          state_q <= StData;
        end
        StData: begin
          state_q  <= StIdle;
          rvalid_q <= win_id_q ? 2'b10 : 2'b01;
          if (!win_we_q) begin
            if (win_id_q) begin
              m1_rdata_q <= bus_rdata_i;
            end else begin
              m0_rdata_q <= bus_rdata_i;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign m0_gnt_o    = gnt_q[0];
  assign m1_gnt_o    = gnt_q[1];
  assign m0_rvalid_o = rvalid_q[0];
  assign m1_rvalid_o = rvalid_q[1];
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_size_o  = bus_size_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_rd_o    = bus_rd_q;
  assign bus_we_o    = bus_we_q;

endmodule

// File: doc/soc_bus_arb.md
SOC_BUS_ARB -- requirements
Module: soc_bus_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, data width of all data ports.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have ports mN_req_i, input, 1, transaction request from master N (N=0 core dbus, N=1 DMA/loader).
REQ-006 SHALL have ports mN_addr_i, input, ADDR_W, byte address from master N.
REQ-007 SHALL have ports mN_we_i, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have ports mN_size_i, input, 3, access size code, passed through unchanged.
REQ-009 SHALL have ports mN_wdata_i, input, DATA_W, write data from master N.
REQ-010 SHALL have ports mN_gnt_o, output, 1, one-cycle grant pulse to master N.
REQ-011 SHALL have ports mN_rvalid_o, output, 1, one-cycle completion pulse to master N.
REQ-012 SHALL have ports mN_rdata_o, output, DATA_W, registered read data to master N.
REQ-013 SHALL have ports bus_addr_o (ADDR_W), bus_size_o (3), bus_wdata_o (DATA_W), outputs, command to the shared slave bus decoder.
REQ-014 SHALL have ports bus_rd_o and bus_we_o, outputs, 1 each, read/write strobes to the slave bus decoder.
REQ-015 SHALL have port bus_rdata_i, input, DATA_W, read data returned by the slave bus decoder.

Function
REQ-016 SHALL implement the FSM IDLE -> ADDR -> DATA -> IDLE, with exactly one transaction in flight.
REQ-017 In IDLE with any mN_req_i high, SHALL select a winner, register its addr/size/wdata/we and the winner ID, and go to ADDR; with no request, SHALL stay in IDLE.
REQ-018 In ADDR, SHALL assert the winner's mN_gnt_o plus bus_rd_o (read) or bus_we_o (write) for exactly one cycle, then go to DATA.
REQ-019 In DATA, SHALL keep bus_addr_o/size/wdata stable, hold both strobes low, and register bus_rdata_i into the winner's mN_rdata_o for reads only; then go to IDLE.
REQ-020 SHALL pulse the winner's mN_rvalid_o for one cycle in the cycle after DATA, for reads and writes; the other master's mN_rdata_o SHALL NOT change.
REQ-021 Latency: request sampled at edge k -> grant in cycle k+1 -> rvalid in cycle k+3; peak throughput one transaction per 3 cycles.
REQ-022 Arbitration in the rvalid cycle (IDLE) SHALL be allowed, so back-to-back transactions have no bubble beyond the 3-cycle cadence.
REQ-023 Round-robin: on a simultaneous request, the master not granted most recently SHALL win; a sole requester SHALL always win.
REQ-024 Master protocol: req and command SHALL be held stable until mN_gnt_o; a request withdrawn after capture SHALL still complete; req high after rvalid SHALL be treated as a new request.
REQ-025 A request arriving while the other master's transaction is in flight SHALL wait and SHALL NOT corrupt the in-flight command.

Reset
REQ-026 On rst_n_i low, SHALL enter IDLE at once, with all outputs 0 and the last-granted pointer = 1 (m0 wins the first tie).
REQ-027 Reset asserted during ADDR or DATA SHALL abort the transaction, with no gnt/rvalid pulse after reset release.

Configuration
REQ-028 With macro SOC_BUS_ARB_FIXED_PRIO_EN defined, SHALL use fixed priority: m0 wins every tie and the pointer is unused. Undefined, SHALL use round-robin per REQ-023.

Verification
REQ-029 m0 reads 0x1000_0010 alone, bus_rdata_i=0xDEADBEEF -> m0_gnt_o at k+1 with bus_rd_o=1, m0_rvalid_o at k+3, m0_rdata_o=0xDEADBEEF, m1 outputs 0.
REQ-030 m1 writes 0x1000_0020, data 0x12345678, size 2 -> bus_we_o one cycle, bus_wdata_o=0x12345678, bus_size_o=2; m1_rvalid_o pulses; m1_rdata_o unchanged.
REQ-031 Both request continuously after reset -> grant order m0,m1,m0,m1, a grant every 3 cycles; with SOC_BUS_ARB_FIXED_PRIO_EN -> m0 only.
REQ-032 m1 requests in m0's ADDR cycle -> m0 completes intact; m1_gnt_o in the cycle after m0_rvalid_o.
REQ-033 rst_n_i low during DATA of a read -> all outputs 0 immediately; no rvalid after release; next request served normally.
